// File: rtl/dffn_pipe_bank.sv
// dffn_pipe_bank: falling-edge WIDTH x DEPTH register pipeline with valid tags, stall, scan chain and occupancy count
module dffn_pipe_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         CLKN,
    input  logic                         R,
    input  logic                         E,
    input  logic [WIDTH-1:0]             D,
    input  logic                         DV,
    input  logic                         SE,
    input  logic                         SI,
    output logic [WIDTH-1:0]             Q,
    output logic                         QV,
    output logic                         SO,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);
    localparam int SW = WIDTH + 1;
    localparam int L  = DEPTH * SW;
    localparam int OW = $clog2(DEPTH + 1);
    logic [L-1:0] chain_q, chain_d;
    logic         ctl_p;
    assign ctl_p = ^{R, SE, E};
    // stage k lives at chain bits [k*SW +: SW]: data low, valid on top, so the scan order is the bit order
    always_comb begin
        chain_d = R  ? {DEPTH{{1'b0, RESET_VAL}}}
                : SE ? {chain_q[L-2:0], SI}
                : E  ? (chain_q << SW) | L'({DV, D})
                :      chain_q;
        chain_d = chain_d ^ {L{ctl_p ^ ctl_p}};
    end
    always_ff @(negedge CLKN) chain_q <= chain_d;
    assign Q  = chain_q[L-2 -: WIDTH];
    assign QV = chain_q[L-1];
    assign SO = chain_q[L-1];
    always_comb begin
        OCC = '0;
        for (int k = 0; k < DEPTH; k++) OCC = OCC + OW'(chain_q[k*SW+WIDTH]);
    end
endmodule

// File: tb/tb_dffn_pipe_bank.sv
// tb_dffn_pipe_bank: directed scoreboard bench over three configurations (8x3, 2x2, 8x1)
module tb_dffn_pipe_bank;
    typedef struct {
        int         id;
        logic [7:0] q;
        logic       qv;
        logic [1:0] occ;
    } exp_t;

    logic clk_n = 1'b1;
    always #5 clk_n = ~clk_n;

    logic       a_r = 1, a_e = 0, a_dv = 0, a_se = 0, a_si = 0;
    logic [7:0] a_d = 0;
    logic [7:0] a_q;
    logic       a_qv, a_so;
    logic [1:0] a_occ;

    logic       b_r = 1, b_e = 0, b_dv = 0, b_se = 0, b_si = 0;
    logic [1:0] b_d = 0;
    logic [1:0] b_q;
    logic       b_qv, b_so;
    logic [1:0] b_occ;

    logic       c_r = 1, c_e = 0, c_dv = 0, c_se = 0, c_si = 0;
    logic [7:0] c_d = 0;
    logic [7:0] c_q;
    logic       c_qv, c_so;
    logic [0:0] c_occ;

    dffn_pipe_bank #(.WIDTH(8), .DEPTH(3)) u_a (
        .CLKN(clk_n), .R(a_r), .E(a_e), .D(a_d), .DV(a_dv), .SE(a_se), .SI(a_si),
        .Q(a_q), .QV(a_qv), .SO(a_so), .OCC(a_occ));
    dffn_pipe_bank #(.WIDTH(2), .DEPTH(2)) u_b (
        .CLKN(clk_n), .R(b_r), .E(b_e), .D(b_d), .DV(b_dv), .SE(b_se), .SI(b_si),
        .Q(b_q), .QV(b_qv), .SO(b_so), .OCC(b_occ));
    dffn_pipe_bank #(.WIDTH(8), .DEPTH(1)) u_c (
        .CLKN(clk_n), .R(c_r), .E(c_e), .D(c_d), .DV(c_dv), .SE(c_se), .SI(c_si),
        .Q(c_q), .QV(c_qv), .SO(c_so), .OCC(c_occ));

    exp_t qa[$], qb[$], qc[$];
    int   checks = 0, failures = 0, n_id = 0;

    task automatic chk(input string n, input exp_t x, input logic [7:0] q, input logic qv,
                       input logic so, input logic [1:0] occ);
        checks++;
        if ({q, qv, so, occ} !== {x.q, x.qv, x.qv, x.occ}) begin
            failures++;
            $display("FAIL %s step%0d: got q=%h qv=%b so=%b occ=%0d, want q=%h qv=%b so=%b occ=%0d",
                     n, x.id, q, qv, so, occ, x.q, x.qv, x.qv, x.occ);
        end
    endtask

    always @(posedge clk_n) begin
        if (qa.size() > 0) chk("A8x3", qa.pop_front(), a_q, a_qv, a_so, a_occ);
        if (qb.size() > 0) chk("B2x2", qb.pop_front(), {6'b0, b_q}, b_qv, b_so, b_occ);
        if (qc.size() > 0) chk("C8x1", qc.pop_front(), c_q, c_qv, c_so, {1'b0, c_occ});
    end

    task automatic st(input int s, input logic r, input logic e, input logic se, input logic si,
                      input logic dv, input logic [7:0] d,
                      input logic [7:0] eq, input logic eqv, input logic [1:0] eocc);
        exp_t x;
        @(posedge clk_n);
        #1;
        {a_r, a_e, a_se} = 3'b000;
        {b_r, b_e, b_se} = 3'b000;
        {c_r, c_e, c_se} = 3'b000;
        x.id = n_id++;
        x.q = eq;
        x.qv = eqv;
        x.occ = eocc;
        case (s)
            0: begin {a_r, a_e, a_se, a_si, a_dv} = {r, e, se, si, dv}; a_d = d; qa.push_back(x); end
            1: begin {b_r, b_e, b_se, b_si, b_dv} = {r, e, se, si, dv}; b_d = d[1:0]; qb.push_back(x); end
            default: begin {c_r, c_e, c_se, c_si, c_dv} = {r, e, se, si, dv}; c_d = d; qc.push_back(x); end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal end");
        $fatal(1);
    end

    initial begin
        // A: reset overrides everything, then streaming
        st(0, 1, 1, 1, 1, 1, 8'hFF, 8'h00, 0, 0);
        st(0, 0, 1, 0, 0, 1, 8'h11, 8'h00, 0, 1);
        st(0, 0, 1, 0, 0, 1, 8'h22, 8'h00, 0, 2);
        st(0, 0, 1, 0, 0, 0, 8'h33, 8'h11, 1, 2);
        st(0, 0, 1, 0, 0, 1, 8'h44, 8'h22, 1, 2);
        st(0, 0, 1, 0, 0, 1, 8'h55, 8'h33, 0, 2);
        st(0, 0, 1, 0, 0, 1, 8'h66, 8'h44, 1, 3);
        // A: reset on a full pipe with E=1, then a fresh word exits three edges later
        st(0, 1, 1, 0, 0, 1, 8'h77, 8'h00, 0, 0);
        st(0, 0, 1, 0, 0, 1, 8'h88, 8'h00, 0, 1);
        st(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        st(0, 0, 1, 0, 0, 0, 8'h00, 8'h88, 1, 1);
        // A: stall on edge 2, then E toggling every edge
        st(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        st(0, 0, 1, 0, 0, 1, 8'h11, 8'h00, 0, 1);
        st(0, 0, 0, 0, 0, 1, 8'h22, 8'h00, 0, 1);
        st(0, 0, 1, 0, 0, 1, 8'h22, 8'h00, 0, 2);
        st(0, 0, 1, 0, 0, 0, 8'h33, 8'h11, 1, 2);
        st(0, 0, 0, 0, 0, 1, 8'h99, 8'h11, 1, 2);
        st(0, 0, 1, 0, 0, 1, 8'h44, 8'h22, 1, 2);
        st(0, 0, 0, 0, 0, 1, 8'h99, 8'h22, 1, 2);
        st(0, 0, 1, 0, 0, 0, 8'h00, 8'h33, 0, 1);
        st(0, 0, 0, 0, 0, 1, 8'h99, 8'h33, 0, 1);
        st(0, 0, 1, 0, 0, 0, 8'h00, 8'h44, 1, 1);
        // A: reset during a stall and during a scan
        st(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        st(0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        st(0, 1, 1, 1, 1, 1, 8'hFF, 8'h00, 0, 0);
        // B: scan chain of 6, pattern 1,0,1,1,0,1 then six zeros
        st(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        st(1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        st(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        st(1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 0, 1);
        st(1, 0, 0, 1, 1, 0, 8'h00, 8'h01, 0, 0);
        st(1, 0, 1, 1, 0, 0, 8'h00, 8'h02, 0, 1);
        st(1, 0, 0, 1, 1, 0, 8'h00, 8'h01, 1, 2);
        st(1, 0, 0, 1, 0, 0, 8'h00, 8'h03, 0, 0);
        st(1, 0, 0, 1, 0, 0, 8'h00, 8'h02, 1, 2);
        st(1, 0, 0, 1, 0, 0, 8'h00, 8'h01, 1, 1);
        st(1, 0, 0, 1, 0, 0, 8'h00, 8'h02, 0, 0);
        st(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 1);
        st(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        // B: scan a valid word into stage 0, then leave scan and advance it
        st(1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        st(1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
        st(1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1);
        st(1, 0, 1, 0, 0, 0, 8'h00, 8'h03, 1, 1);
        // C: single-stage register with hold and a data bubble
        st(2, 1, 1, 1, 1, 1, 8'hFF, 8'h00, 0, 0);
        st(2, 0, 1, 0, 0, 1, 8'hA5, 8'hA5, 1, 1);
        st(2, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 1, 1);
        st(2, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 1, 1);
        st(2, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 1, 1);
        st(2, 0, 1, 0, 0, 0, 8'h3C, 8'h3C, 0, 0);
        repeat (3) @(posedge clk_n);
        #2;
        checks++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", qa.size() + qb.size() + qc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
